raster_csr_bank: RTL

- Multi-context raster CSR store.
- Each context has a shadow register set and an active register set.
- Cores write shadow registers individually. A commit copies shadow to active atomically, so the raster front-end never sees a half-programmed state.
- Sits between the core CSR write path and the raster tile/primitive fetch front-end, which reads complete packed state per context over a valid/ready port.

---
 rtl/raster_csr_bank_if.sv | 47 ++++
 rtl/raster_csr_bank.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/raster_csr_bank_if.sv
// Bus bundle for raster_csr_bank: core shadow-write and commit path, plus the
// front-end state request/response port.
//
// Handshake: a request transfers on a rising edge where req_valid && req_ready;
// a response transfers on a rising edge where rsp_valid && rsp_ready.  While
// rsp_valid is high and rsp_ready is low, every rsp_* signal holds its value.
// Writes and commits have no ready; they always take effect at the edge.
interface raster_csr_bank_if #(
  parameter int NUM_CTX        = 4,
  parameter int CSR_DATA_BITS  = 32,
  parameter int TILE_DATA_BITS = 16,
  parameter int CTX_BITS       = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1
) ();
  localparam int RSP_BITS = 4 * CSR_DATA_BITS + 4 * TILE_DATA_BITS;

  logic                     wr_valid;
  logic [CTX_BITS-1:0]      wr_ctx;
  logic [2:0]               wr_addr;
  logic [CSR_DATA_BITS-1:0] wr_data;
  logic                     commit_valid;
  logic [CTX_BITS-1:0]      commit_ctx;
  logic                     commit_err;
  logic                     req_valid;
  logic [CTX_BITS-1:0]      req_ctx;
  logic                     req_ready;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [CTX_BITS-1:0]      rsp_ctx;
  logic                     rsp_live;
  logic [RSP_BITS-1:0]      rsp_data;

  // Core / front-end side
  modport master (
    output wr_valid, wr_ctx, wr_addr, wr_data,
    output commit_valid, commit_ctx,
    output req_valid, req_ctx, rsp_ready,
    input  commit_err, req_ready, rsp_valid, rsp_ctx, rsp_live, rsp_data
  );

  // CSR bank side
  modport slave (
    input  wr_valid, wr_ctx, wr_addr, wr_data,
    input  commit_valid, commit_ctx,
    input  req_valid, req_ctx, rsp_ready,
    output commit_err, req_ready, rsp_valid, rsp_ctx, rsp_live, rsp_data
  );
endinterface

// File: rtl/raster_csr_bank.sv
// Multi-context raster CSR store with shadow/active register sets.
// Cores program shadow fields one at a time; a commit copies the whole shadow
// set of a context into its active set in one edge, so the raster front-end
// only ever reads fully programmed state.
//
// Optional build macro RASTER_CSR_CHECK_EN: when defined, a commit whose
// shadow pidx_size, tile_width or tile_height is zero is rejected and
// commit_err pulses for one cycle; when undefined, commit_err is tied low.
//
// Field map (wr_addr): 0 pidx_addr, 1 pidx_size, 2 pbuf_addr, 3 pbuf_stride,
// 4 tile_left, 5 tile_top, 6 tile_width, 7 tile_height.
module raster_csr_bank #(
  parameter int NUM_CTX        = 4,
  parameter int CSR_DATA_BITS  = 32,
  parameter int TILE_DATA_BITS = 16,
  parameter int CTX_BITS       = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1
) (
  input logic              clk,
  input logic              reset,
  raster_csr_bank_if.slave bus
);
  localparam int RSP_BITS = 4 * CSR_DATA_BITS + 4 * TILE_DATA_BITS;

  // Address/size/stride fields (index 0..3) and tile fields (index 0..3 = addr 4..7)
  logic [CSR_DATA_BITS-1:0]  shadow_csr  [NUM_CTX][4];
  logic [TILE_DATA_BITS-1:0] shadow_tile [NUM_CTX][4];
  logic [CSR_DATA_BITS-1:0]  active_csr  [NUM_CTX][4];
  logic [TILE_DATA_BITS-1:0] active_tile [NUM_CTX][4];
  logic [NUM_CTX-1:0]        live;

  logic                wr_hit;
  logic                commit_hit;
  logic                commit_ok;
  logic                req_hit;
  logic                accept;
  logic [RSP_BITS-1:0] req_state;

  logic                rsp_valid_q;
  logic [CTX_BITS-1:0] rsp_ctx_q;
  logic                rsp_live_q;
  logic [RSP_BITS-1:0] rsp_data_q;

  // Out-of-range contexts are silently ignored by every path
  assign wr_hit     = bus.wr_valid     && (32'(bus.wr_ctx)     < NUM_CTX);
  assign commit_hit = bus.commit_valid && (32'(bus.commit_ctx) < NUM_CTX);
  assign req_hit    = 32'(bus.req_ctx) < NUM_CTX;

`ifdef RASTER_CSR_CHECK_EN
  // A zero-sized index buffer or empty tile is never allowed to go live
  assign commit_ok = (shadow_csr[bus.commit_ctx][1]  != '0) &&
                     (shadow_tile[bus.commit_ctx][2] != '0) &&
                     (shadow_tile[bus.commit_ctx][3] != '0);
`else
  assign commit_ok = 1'b1;
`endif

  // Shadow writes; tile fields keep only their low TILE_DATA_BITS bits
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < NUM_CTX; c++) begin
        for (int f = 0; f < 4; f++) begin
          shadow_csr[c][f]  <= '0;
          shadow_tile[c][f] <= '0;
        end
      end
    end else if (wr_hit) begin
      if (bus.wr_addr[2]) begin
        shadow_tile[bus.wr_ctx][bus.wr_addr[1:0]] <= bus.wr_data[TILE_DATA_BITS-1:0];
      end else begin
        shadow_csr[bus.wr_ctx][bus.wr_addr[1:0]] <= bus.wr_data;
      end
    end
  end

  // Commit: copy the pre-edge shadow set, so a same-cycle write waits for the next commit
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      live <= '0;
      for (int c = 0; c < NUM_CTX; c++) begin
        for (int f = 0; f < 4; f++) begin
          active_csr[c][f]  <= '0;
          active_tile[c][f] <= '0;
        end
      end
    end else if (commit_hit && commit_ok) begin
      for (int f = 0; f < 4; f++) begin
        active_csr[bus.commit_ctx][f]  <= shadow_csr[bus.commit_ctx][f];
        active_tile[bus.commit_ctx][f] <= shadow_tile[bus.commit_ctx][f];
      end
      live[bus.commit_ctx] <= 1'b1;
    end
  end

`ifdef RASTER_CSR_CHECK_EN
  logic commit_err_q;

  // One-cycle rejection pulse, registered
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      commit_err_q <= 1'b0;
    end else begin
      commit_err_q <= commit_hit && !commit_ok;
    end
  end

  assign bus.commit_err = commit_err_q;
`else
  assign bus.commit_err = 1'b0;
`endif

  // Packed snapshot of the requested context, pidx_addr in the MSBs
  always_comb begin
    req_state = '0;
    if (req_hit) begin
      req_state = {active_csr[bus.req_ctx][0],  active_csr[bus.req_ctx][1],
                   active_csr[bus.req_ctx][2],  active_csr[bus.req_ctx][3],
                   active_tile[bus.req_ctx][0], active_tile[bus.req_ctx][1],
                   active_tile[bus.req_ctx][2], active_tile[bus.req_ctx][3]};
    end
  end

  // The single output slot frees up in the same cycle its response is consumed
  assign bus.req_ready = !rsp_valid_q || bus.rsp_ready;
  assign accept        = bus.req_valid && bus.req_ready;

  // Output register: loads the pre-commit active state on accept, holds under stall
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_valid_q <= 1'b0;
      rsp_ctx_q   <= '0;
      rsp_live_q  <= 1'b0;
      rsp_data_q  <= '0;
    end else if (accept) begin
      rsp_valid_q <= 1'b1;
      rsp_ctx_q   <= bus.req_ctx;
      rsp_live_q  <= req_hit && live[bus.req_ctx];
      rsp_data_q  <= req_state;
    end else if (bus.rsp_ready) begin
      rsp_valid_q <= 1'b0;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_ctx   = rsp_ctx_q;
  assign bus.rsp_live  = rsp_live_q;
  assign bus.rsp_data  = rsp_data_q;
endmodule
